// File: rtl/data_mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit_if
//   Word-wide handshaked bus between the load/store unit and data memory.
//   master : the load/store unit (drives request, address, data, strobes)
//   slave  : the data memory (drives mem_ready and mem_rdata)
//
//   mem_req    request, held stable until mem_ready
//   mem_we     1 = write, 0 = read
//   mem_addr   word-aligned byte address
//   mem_wdata  lane-positioned store data
//   mem_wstrb  byte enables, 0000 on reads
//   mem_ready  memory accepts/completes the access this cycle
//   mem_rdata  read word, meaningful only while mem_ready = 1
// -----------------------------------------------------------------------------
interface data_mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//   Load/store unit sitting on the core's data port. A core load/store request
//   is turned into one registered word access on the data memory bus, with
//   byte/halfword/word sizing, byte strobes, load sign/zero extension,
//   misalignment detection and a memory timeout. The core is stalled while an
//   access is outstanding.
//
//   Ports
//     clk, rst      clock; asynchronous active-low reset
//     req_read      core load request (level, held while stall = 1)
//     req_write     core store request (wins if both are set)
//     req_addr      byte address
//     req_wdata     store data, low bytes significant
//     req_func3     RISC-V load/store func3
//     stall         freeze core pipeline
//     resp_valid    one-cycle pulse, access finished
//     load_data     extended load result, valid with resp_valid
//     err_misalign  one-cycle pulse, misaligned address or illegal func3
//     err_timeout   one-cycle pulse, memory did not answer in time
//     mem           data memory bus (master side)
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_read,
    input  logic                          req_write,
    input  logic [31:0]                   req_addr,
    input  logic [31:0]                   req_wdata,
    input  logic [2:0]                    req_func3,
    output logic                          stall,
    output logic                          resp_valid,
    output logic [31:0]                   load_data,
    output logic                          err_misalign,
    output logic                          err_timeout,
    data_mem_access_unit_if.master        mem
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    // Size codes: 0 byte, 1 half, 2 word, 3 illegal func3.
    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_BAD = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    function automatic logic [1:0] f_size(input logic is_store, input logic [2:0] f3);
        logic [1:0] sz;
        sz = SZ_BAD;
        if (is_store) begin
            case (f3)
                3'b000:  sz = SZ_B;
                3'b001:  sz = SZ_H;
                3'b010:  sz = SZ_W;
                default: sz = SZ_BAD;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b100: sz = SZ_B;
                3'b001, 3'b101: sz = SZ_H;
                3'b010:         sz = SZ_W;
                default:        sz = SZ_BAD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] f_wstrb(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] s;
        case (sz)
            SZ_B:    s = 4'b0001 << off;
            SZ_H:    s = 4'b0011 << {off[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Replicate the store value across lanes; the strobes pick the live bytes.
    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] w;
        case (sz)
            SZ_B:    w = {4{wd[7:0]}};
            SZ_H:    w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // func3[2] = 1 selects zero extension (LBU/LHU).
    function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [2:0]  func3_q, func3_d;
    logic [1:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic        err_mis_q, err_mis_d;
    logic        err_to_q, err_to_d;
    logic        stall_c;

    logic        req_any;
    logic [1:0]  req_size;
    logic        req_bad;

    assign req_any  = req_read | req_write;
    assign req_size = f_size(req_write, req_func3);
    assign req_bad  = (req_size == SZ_BAD) || f_misaligned(req_size, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            func3_q      <= '0;
            off_q        <= '0;
            resp_valid_q <= 1'b0;
            load_data_q  <= '0;
            err_mis_q    <= 1'b0;
            err_to_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            func3_q      <= func3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            load_data_q  <= load_data_d;
            err_mis_q    <= err_mis_d;
            err_to_q     <= err_to_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        func3_d      = func3_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        resp_valid_d = 1'b0;
        err_mis_d    = 1'b0;
        err_to_d     = 1'b0;
        stall_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (req_bad) begin
                        // Rejected without a bus access; the core is not held,
                        // the response pulses on the following cycle.
                        err_mis_d    = 1'b1;
                        resp_valid_d = 1'b1;
                        load_data_d  = '0;
                    end else begin
                        stall_c     = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_write ? f_wdata(req_size, req_wdata) : '0;
                        mem_wstrb_d = req_write ? f_wstrb(req_size, req_addr[1:0]) : 4'b0000;
                        func3_d     = req_func3;
                        off_d       = req_addr[1:0];
                        cnt_d       = '0;
                        state_d     = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (mem.mem_ready) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        load_data_d = f_extend(func3_q, off_q, mem.mem_rdata);
                    end
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d    = 1'b0;
                    load_data_d  = '0;
                    err_to_d     = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                // The core advances this cycle; its still-visible request is
                // the one just completed and must not be reissued.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating with rst keeps stall low while reset is held even if the core
    // still presents a request.
    assign stall         = stall_c & rst;
    assign resp_valid    = resp_valid_q;
    assign load_data     = load_data_q;
    assign err_misalign  = err_mis_q;
    assign err_timeout   = err_to_q;

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Load/store unit directly downstream of the CPU core's data port (data_read/data_write/data_addr/data_in/data_out).
- Converts a core memory request into a registered, handshaked word access to data memory.
- Handles byte/halfword/word sizing, byte strobes, load sign/zero extension, misalignment and memory timeout.
- Stalls the core while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without mem_ready before the access is aborted; range 1..65535.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req_read  input  1  core load request (level, held while stall=1)
- req_write  input  1  core store request (level, held while stall=1)
- req_addr  input  32  byte address from ALU
- req_wdata  input  32  store data (rs2), low bytes significant
- req_func3  input  3  RISC-V load/store func3
- stall  output  1  freeze core pipeline
- resp_valid  output  1  one-cycle pulse, access finished
- load_data  output  32  extended load result, valid with resp_valid
- err_misalign  output  1  one-cycle pulse, misaligned or illegal func3
- err_timeout  output  1  one-cycle pulse, memory did not answer
- mem_req  output  1  request to data memory, held until mem_ready
- mem_we  output  1  1=write, 0=read
- mem_addr  output  32  word address {req_addr[31:2],2'b00}
- mem_wdata  output  32  lane-shifted store data
- mem_wstrb  output  4  byte enables (0000 on reads)
- mem_ready  input  1  memory accepts/completes access this cycle
- mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- States: IDLE, WAIT, DONE.
- Reset (rst=0, async): state=IDLE, counter=0, all outputs 0. Mid-WAIT reset drops mem_req immediately, with no response.
- Request present in IDLE: req_read|req_write=1. If both are set, the access is a write.
- Size from func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other func3 is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- IDLE with illegal or misaligned request:
  - No memory access.
  - Same cycle: err_misalign=1 (registered pulse on the next edge), resp_valid=1 on the next cycle, load_data=0, stall=0.
  - The core advances.
- IDLE with a legal request:
  - stall=1 combinationally.
  - At the edge: register mem_addr, mem_we, mem_wdata, mem_wstrb, func3 and addr[1:0]. Set mem_req=1, counter=0, next state WAIT.
- Store lanes:
  - SB: wstrb=0001<<addr[1:0], wdata={4{byte}}.
  - SH: wstrb=0011<<{addr[1],1'b0}, wdata={2{half}}.
  - SW: wstrb=1111.
- WAIT:
  - stall=1; mem_req and all mem_* outputs held stable.
  - mem_ready=1: mem_req=0. For a load, select the byte/half by saved addr[1:0], sign- or zero-extend into load_data. Next state DONE.
  - mem_ready=0: counter+1. When counter reaches TIMEOUT_CYCLES-1 without ready: mem_req=0, load_data=0, err_timeout=1 in DONE, next state DONE.
- DONE:
  - resp_valid=1, stall=0 for exactly one cycle. Errors pulse here.
  - Next state is IDLE unconditionally. The request still visible this cycle is NOT re-issued, because the core advances on this cycle.
- Latency: request at T0; mem_req high T1; ready at T1 gives resp_valid at T2. Minimum 2 stall cycles (T0,T1).
- load_data holds its last value until the next resp_valid. Stores leave load_data unchanged, except errors, which force 0.
- mem_rdata ignored when mem_ready=0. mem_ready in IDLE/DONE ignored.

Test Plan:
- LW addr=0x100, mem answers T1 with 0xDEADBEEF → mem_addr=0x100, wstrb=0000, stall high T0–T1, resp_valid T2, load_data=0xDEADBEEF.
- LB addr=0x103, mem_rdata=0x80123456 → load_data=0xFFFFFF80. Same with LBU → 0x00000080. LHU addr=0x102 → 0x00008012.
- SH addr=0x206, wdata=0x0000ABCD → mem_addr=0x204, wstrb=1100, mem_wdata=0xABCDABCD, mem_we=1. SB addr=0x201 → wstrb=0010.
- LW addr=0x102 → no mem_req, err_misalign pulse, load_data=0, stall never high. func3=011 load → same.
- TIMEOUT_CYCLES=4, mem_ready never asserted → mem_req high 4 cycles then low, err_timeout and resp_valid pulse together, load_data=0, back to IDLE.
- rst low during WAIT → mem_req, stall 0 immediately. After release, a new LW completes normally with the 2-cycle latency.
